// File: rtl/sprite_window_ctrl_if.sv
// sprite_window_ctrl_if
//   Move-request handshake between game/keyboard logic and the sprite window
//   controller.
//   master (game logic) : drives move_req, move_dir, scroll_en; observes ready, move_ack
//   slave  (controller) : observes move_req, move_dir, scroll_en; drives ready, move_ack
//   move_req  1  request to move the window; taken only while ready is high
//   move_dir  2  00 left, 01 right, 10 up, 11 down; qualified by move_req
//   scroll_en 1  lets the background scroll advance at each frame update
//   ready     1  high when no request is pending
//   move_ack  1  one-cycle pulse when the pending move is applied
interface sprite_window_ctrl_if;
  logic       move_req;
  logic [1:0] move_dir;
  logic       scroll_en;
  logic       ready;
  logic       move_ack;

  modport master (
    output move_req,
    output move_dir,
    output scroll_en,
    input  ready,
    input  move_ack
  );

  modport slave (
    input  move_req,
    input  move_dir,
    input  scroll_en,
    output ready,
    output move_ack
  );
endinterface

// File: rtl/sprite_window_ctrl.sv
// sprite_window_ctrl
//   Frame-synchronous owner of the sprite window origin and the background
//   scroll offset. One move request per frame is captured from game logic and
//   applied, together with the scroll advance, in a single cycle at the start
//   of vertical blank, so everything the address generator sees is stable
//   through active video.
// Ports
//   clk        in   pixel/system clock
//   rst        in   asynchronous active-high reset
//   h_cnt      in   10-bit horizontal counter from the VGA timing block
//   v_cnt      in   10-bit vertical counter from the VGA timing block
//   bus        slave modport of sprite_window_ctrl_if (move handshake, scroll_en)
//   win_x      out  window left edge, 0..H_ACTIVE-WIN_W
//   win_y      out  window top edge, 0..V_ACTIVE-WIN_H
//   scroll     out  background line offset, 0..SCROLL_MAX
//   frame_tick out  one-cycle pulse during the update cycle
module sprite_window_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int WIN_W      = 150,
  parameter int WIN_H      = 180,
  parameter int WIN_X0     = 405,
  parameter int WIN_Y0     = 150,
  parameter int STEP       = 10,
  parameter int SCROLL_MAX = 239,
  parameter int SCROLL_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  sprite_window_ctrl_if.slave        bus,
  output logic [9:0]                 win_x,
  output logic [9:0]                 win_y,
  output logic [7:0]                 scroll,
  output logic                       frame_tick
);

  localparam logic [9:0]  V_ACTIVE_C   = 10'(V_ACTIVE);
  localparam logic [9:0]  WIN_X0_C     = 10'(WIN_X0);
  localparam logic [9:0]  WIN_Y0_C     = 10'(WIN_Y0);
  localparam logic [10:0] STEP_C       = 11'(STEP);
  localparam logic [10:0] X_MAX_C      = 11'(H_ACTIVE - WIN_W);
  localparam logic [10:0] Y_MAX_C      = 11'(V_ACTIVE - WIN_H);
  localparam logic [7:0]  SCROLL_MAX_C = 8'(SCROLL_MAX);
  localparam logic [7:0]  DIV_LAST_C   = 8'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    WAIT_TOP = 2'd2
  } state_t;

  // Saturating decrement by STEP, floored at 0; 11-bit math avoids wrap.
  function automatic logic [9:0] dec_sat(input logic [9:0] pos);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p >= STEP_C) begin
      dec_sat = 10'(p - STEP_C);
    end else begin
      dec_sat = 10'd0;
    end
  endfunction

  // Saturating increment by STEP, clamped at lim.
  function automatic logic [9:0] inc_sat(input logic [9:0] pos, input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + STEP_C;
    if (sum > lim) begin
      inc_sat = 10'(lim);
    end else begin
      inc_sat = 10'(sum);
    end
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        sof_s;
  logic        upd_s;
  logic        take_s;
  logic        pend_r;
  logic        ready_r;
  logic        ack_r;
  logic [1:0]  dir_r;
  logic        move_vld_s;
  logic [1:0]  move_dir_s;
  logic [9:0]  win_x_nxt_s;
  logic [9:0]  win_y_nxt_s;
  logic [7:0]  div_r;
  logic [7:0]  div_nxt_s;
  logic [7:0]  scroll_nxt_s;

  assign sof_s     = (v_cnt == V_ACTIVE_C) && (h_cnt == 10'd0);
  assign take_s    = bus.move_req && ready_r;
  assign bus.ready    = ready_r;
  assign bus.move_ack = ack_r;

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next state; upd_s fires once per frame on the first sof cycle seen in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    upd_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (sof_s) begin
          state_nxt_s = UPDATE;
          upd_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      UPDATE: begin
        state_nxt_s = WAIT_TOP;
      end
      WAIT_TOP: begin
        if (v_cnt == 10'd0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_TOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Move to apply at update: the pending one, or one offered on the sof cycle itself.
  always_comb begin
    move_vld_s  = 1'b0;
    move_dir_s  = dir_r;
    win_x_nxt_s = win_x;
    win_y_nxt_s = win_y;
    if (pend_r) begin
      move_vld_s = 1'b1;
      move_dir_s = dir_r;
    end else if (take_s) begin
      move_vld_s = 1'b1;
      move_dir_s = bus.move_dir;
    end else begin
      move_vld_s = 1'b0;
      move_dir_s = dir_r;
    end
    case (move_dir_s)
      2'b00:   win_x_nxt_s = dec_sat(win_x);
      2'b01:   win_x_nxt_s = inc_sat(win_x, X_MAX_C);
      2'b10:   win_y_nxt_s = dec_sat(win_y);
      2'b11:   win_y_nxt_s = inc_sat(win_y, Y_MAX_C);
      default: begin
        win_x_nxt_s = win_x;
        win_y_nxt_s = win_y;
      end
    endcase
  end

  // Scroll divider: scroll steps once every SCROLL_DIV enabled frames, wrapping after SCROLL_MAX.
  always_comb begin
    div_nxt_s    = div_r;
    scroll_nxt_s = scroll;
    if (bus.scroll_en) begin
      if (div_r == DIV_LAST_C) begin
        div_nxt_s    = 8'd0;
        scroll_nxt_s = (scroll == SCROLL_MAX_C) ? 8'd0 : scroll + 8'd1;
      end else begin
        div_nxt_s    = div_r + 8'd1;
        scroll_nxt_s = scroll;
      end
    end else begin
      div_nxt_s    = div_r;
      scroll_nxt_s = scroll;
    end
  end

  // Request capture, frame update and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x      <= WIN_X0_C;
      win_y      <= WIN_Y0_C;
      scroll     <= 8'd0;
      div_r      <= 8'd0;
      pend_r     <= 1'b0;
      ready_r    <= 1'b1;
      dir_r      <= 2'b00;
      ack_r      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= upd_s;
      ack_r      <= upd_s && move_vld_s;
      if (upd_s) begin
        // A request offered on this same cycle is consumed here and never pends.
        if (move_vld_s) begin
          win_x <= win_x_nxt_s;
          win_y <= win_y_nxt_s;
        end
        pend_r  <= 1'b0;
        ready_r <= 1'b1;
        div_r   <= div_nxt_s;
        scroll  <= scroll_nxt_s;
      end else if (take_s) begin
        pend_r  <= 1'b1;
        ready_r <= 1'b0;
        dir_r   <= bus.move_dir;
      end else begin
        pend_r  <= pend_r;
        ready_r <= ready_r;
      end
    end
  end

endmodule

// File: tb/tb_sprite_window_ctrl.sv
module tb_sprite_window_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] win_x;
  logic [9:0] win_y;
  logic [7:0] scroll;
  logic       frame_tick;

  sprite_window_ctrl_if bus ();

  sprite_window_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .bus        (bus.slave),
    .win_x      (win_x),
    .win_y      (win_y),
    .scroll     (scroll),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_tick = 0;
  int n_ack  = 0;
  logic ready_after_req;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour with plain integer arithmetic.
  int       m_x, m_y, m_scroll, m_frames;
  logic     m_pend, m_armed, m_tick, m_ack;
  logic [1:0] m_dir;

  always @(posedge clk or posedge rst) begin : model
    int x, y, sc, fr;
    logic pd, ar, tk, ak, take;
    logic [1:0] dr, d;
    if (rst) begin
      m_x <= 405; m_y <= 150; m_scroll <= 0; m_frames <= 0;
      m_pend <= 1'b0; m_armed <= 1'b1; m_tick <= 1'b0; m_ack <= 1'b0; m_dir <= 2'b00;
    end else begin
      x = m_x; y = m_y; sc = m_scroll; fr = m_frames;
      pd = m_pend; ar = m_armed; dr = m_dir; tk = 1'b0; ak = 1'b0;
      take = !m_pend && bus.move_req;
      if (m_armed && v_cnt == 10'd480 && h_cnt == 10'd0) begin
        tk = 1'b1;
        ar = 1'b0;
        if (m_pend || take) begin
          d  = m_pend ? m_dir : bus.move_dir;
          ak = 1'b1;
          pd = 1'b0;
          case (d)
            2'b00:   x = (x - 10 < 0) ? 0 : x - 10;
            2'b01:   x = (x + 10 > 640 - 150) ? 640 - 150 : x + 10;
            2'b10:   y = (y - 10 < 0) ? 0 : y - 10;
            default: y = (y + 10 > 480 - 180) ? 480 - 180 : y + 10;
          endcase
        end
        if (bus.scroll_en) begin
          fr = fr + 1;
          if (fr == 2) begin
            fr = 0;
            sc = (sc + 1) % 240;
          end
        end
      end else begin
        if (take) begin
          pd = 1'b1;
          dr = bus.move_dir;
        end
        if (!m_armed && !m_tick && v_cnt == 10'd0) ar = 1'b1;
      end
      m_x <= x; m_y <= y; m_scroll <= sc; m_frames <= fr;
      m_pend <= pd; m_armed <= ar; m_dir <= dr; m_tick <= tk; m_ack <= ak;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("win_x", int'(win_x), m_x);
    check("win_y", int'(win_y), m_y);
    check("scroll", int'(scroll), m_scroll);
    check("ready", int'(bus.ready), m_pend ? 0 : 1);
    check("move_ack", int'(bus.move_ack), int'(m_ack));
    check("frame_tick", int'(frame_tick), int'(m_tick));
    n_tick += int'(frame_tick);
    n_ack  += int'(bus.move_ack);
  end

  task automatic step(input int v, input int h);
    @(negedge clk);
    v_cnt = 10'(v);
    h_cnt = 10'(h);
  endtask

  // One compressed frame; optional request in active video or on the sof cycle.
  task automatic run_frame(input logic req, input logic [1:0] dir, input logic on_sof,
                           input logic req2, input logic [1:0] dir2, input int sof_len);
    step(0, 0);
    bus.move_req = 1'b0;
    step(100, 0);
    bus.move_req = req && !on_sof;
    bus.move_dir = dir;
    step(100, 1);
    ready_after_req = bus.ready;
    bus.move_req = req2;
    bus.move_dir = dir2;
    step(200, 0);
    bus.move_req = 1'b0;
    for (int i = 0; i < sof_len; i++) begin
      step(480, 0);
      bus.move_req = (i == 0) && on_sof && req;
      bus.move_dir = dir;
    end
    step(480, 1);
    bus.move_req = 1'b0;
    step(490, 5);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1);
  endtask

  task automatic moves(input logic [1:0] dir, input int n);
    for (int i = 0; i < n; i++) run_frame(1'b1, dir, 1'b0, 1'b0, 2'b00, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_cnt = 10'd0;
    h_cnt = 10'd0;
    bus.move_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t0, a0;
    rst = 1'b1;
    h_cnt = 10'd0;
    v_cnt = 10'd0;
    bus.move_req = 1'b0;
    bus.move_dir = 2'b00;
    bus.scroll_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset win_x", int'(win_x), 405);
    check("reset win_y", int'(win_y), 150);
    check("reset scroll", int'(scroll), 0);
    check("reset ready", int'(bus.ready), 1);

    // 1: three idle frames
    t0 = n_tick; a0 = n_ack;
    idle_frames(3);
    check("idle ticks", n_tick - t0, 3);
    check("idle acks", n_ack - a0, 0);
    check("idle win_x", int'(win_x), 405);

    // 2: right request in active video
    a0 = n_ack;
    run_frame(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1);
    check("ready drop", int'(ready_after_req), 0);
    check("right win_x", int'(win_x), 415);
    check("right ack", n_ack - a0, 1);
    check("ready after", int'(bus.ready), 1);

    // 3: saturation at each edge
    moves(2'b01, 7);
    check("x 485", int'(win_x), 485);
    moves(2'b01, 1);
    check("x clamp", int'(win_x), 490);
    moves(2'b01, 1);
    check("x hold", int'(win_x), 490);
    moves(2'b10, 15);
    check("y 0", int'(win_y), 0);
    moves(2'b10, 1);
    check("y floor", int'(win_y), 0);
    moves(2'b11, 30);
    check("y 300", int'(win_y), 300);
    moves(2'b11, 1);
    check("y clamp", int'(win_y), 300);

    // 4: second request in a frame is dropped
    do_reset();
    a0 = n_ack;
    run_frame(1'b1, 2'b00, 1'b0, 1'b1, 2'b11, 1);
    check("two req x", int'(win_x), 395);
    check("two req y", int'(win_y), 150);
    check("two req ack", n_ack - a0, 1);

    // 6a: request on the sof cycle applies in the same update
    a0 = n_ack;
    run_frame(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1);
    check("sof req x", int'(win_x), 405);
    check("sof req ack", n_ack - a0, 1);
    check("sof req ready", int'(bus.ready), 1);

    // long sof still updates once
    t0 = n_tick;
    run_frame(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3);
    check("long sof ticks", n_tick - t0, 1);

    // 6b: reset mid-frame with a pending move
    run_frame(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1);
    check("pre-rst x", int'(win_x), 395);
    a0 = n_ack; t0 = n_tick;
    step(0, 0);
    step(100, 0);
    bus.move_req = 1'b1;
    bus.move_dir = 2'b01;
    step(200, 0);
    bus.move_req = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst x", int'(win_x), 405);
    check("rst y", int'(win_y), 150);
    check("rst ready", int'(bus.ready), 1);
    step(300, 0);
    step(480, 0);
    step(480, 1);
    step(490, 0);
    check("rst no ack", n_ack - a0, 0);
    check("rst tick", n_tick - t0, 1);
    check("rst x kept", int'(win_x), 405);

    // 5: scroll sweep
    bus.scroll_en = 1'b1;
    idle_frames(478);
    check("scroll 239", int'(scroll), 239);
    idle_frames(2);
    check("scroll wrap", int'(scroll), 0);
    idle_frames(2);
    check("scroll 1", int'(scroll), 1);
    bus.scroll_en = 1'b0;
    idle_frames(3);
    check("scroll hold", int'(scroll), 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
